l2_cacheline_adaptor: RTL
=========================

Name: l2_cacheline_adaptor

Overview:
Sits directly downstream of the L2 cache controller, between L2 and physical memory.
- Converts the L2's single-transfer 256-bit line requests into 4-beat 64-bit bursts on the memory bus.
- Reads: assembles the four beats into one line. Writes: slices the line into four beats.
- Presents a single-cycle completion pulse back to L2.

Parameters:
- LINE_W, 256, cache line width in bits.
- BEAT_W, 64, memory bus beat width in bits; beats per line NBEATS = LINE_W/BEAT_W = 4.
- ADDR_W, 32, address width.
- TIMEOUT_CYCLES, 1024, max cycles a burst may stall; used only with the optional feature.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- address_i, in, ADDR_W, line address from L2.
- line_i, in, LINE_W, writeback line from L2.
- read_i, in, 1, L2 line-read request.
- write_i, in, 1, L2 line-write request.
- line_o, out, LINE_W, assembled read line.
- resp_o, out, 1, one-cycle completion pulse to L2.
- address_o, out, ADDR_W, burst address to memory.
- burst_o, out, BEAT_W, write beat to memory.
- read_o, out, 1, memory burst-read request.
- write_o, out, 1, memory burst-write request.
- burst_i, in, BEAT_W, read beat from memory.
- resp_i, in, 1, memory beat handshake.
- error_o, out, 1, timeout flag (optional feature only).

Behaviour:
- Reset (synchronous, active-high, clk rising edge) clears all outputs and internal state to 0: line_o, resp_o, address_o, burst_o, read_o, write_o, error_o, beat counter. State <= IDLE.
- States: IDLE, READ, WRITE, DONE.
- IDLE: requests are accepted only here.
  - On read_i or write_i: capture address_i and line_i into internal registers, force address_o[4:0] = 0, clear beat counter.
  - Next state is WRITE if write_i=1, else READ. Write wins if both are high.
  - read_o/write_o rise in the cycle after acceptance (registered).
- READ: read_o=1, address_o stable.
  - Each cycle with resp_i=1 writes burst_i into line_o[BEAT_W*cnt +: BEAT_W], then cnt++.
  - Cycles with resp_i=0 are gaps: no capture, no count.
  - On the beat with cnt==3: next state DONE, read_o drops the following cycle.
- WRITE: write_o=1; burst_o = captured_line[BEAT_W*cnt +: BEAT_W], driven combinationally from cnt.
  - Each resp_i=1 cycle advances cnt; gaps hold the current beat.
  - Beat 3 accepted -> DONE.
- DONE: resp_o=1 for exactly one cycle, then IDLE.
  - line_o is valid in the resp_o cycle and holds until the next read's first beat.
  - A request still high in that IDLE cycle is accepted as new. L2 deasserts its request in the cycle after resp_o, so no re-trigger occurs.
- Beat counter is 2 bits and wraps 3->0 only on the DONE transition. resp_i in IDLE or DONE is ignored.
- Minimum latency for a zero-gap burst: request-to-resp_o = 6 cycles (accept, 4 beats, DONE).
- read_i/write_i changes during READ/WRITE are ignored; the captured address/line is used throughout.
- rst mid-burst: next cycle read_o=write_o=0, state IDLE, partial line discarded (line_o=0).

Optional Feature:
- Macro: L2_CACHELINE_ADAPTOR_TIMEOUT_EN.
- Enabled:
  - A counter runs in READ/WRITE and resets on each resp_i=1.
  - If it reaches TIMEOUT_CYCLES: abort to DONE, pulse resp_o, set error_o=1 (sticky until rst), deassert read_o/write_o.
  - line_o holds the beats captured so far.
- Disabled: no counter, error_o tied 0, bursts wait indefinitely.

Test Plan:
- Read, zero gaps. Stimulus: read_i with address_i=0x0000_1234; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on 4 consecutive resp_i cycles.
  - Response: address_o=0x0000_1220; read_o high exactly 4 cycles; resp_o pulses once 6 cycles after request; line_o = {0x44..,0x33..,0x22..,0x11..}.
- Read with gaps. Stimulus: resp_i pattern 1,0,0,1,1,0,1.
  - Response: same line; resp_o one cycle after the final beat; no beat duplicated.
- Write. Stimulus: write_i with line_i=0xDDDD..CCCC..BBBB..AAAA, one wait cycle before beat 0.
  - Response: burst_o shows 0xAAAA.. until first resp_i, then BB, CC, DD; write_o drops after beat 3; resp_o pulses once.
- Simultaneous read_i=write_i=1 -> write burst issued, read_o never high.
- rst asserted after 2 read beats -> next cycle read_o=0, line_o=0, state IDLE, no resp_o. A following read completes normally.
- TIMEOUT_EN with TIMEOUT_CYCLES=8: read, no resp_i -> resp_o pulse after 8 stalled cycles, error_o=1 and stays 1 until rst.

Source files
------------

// File: rtl/l2_cacheline_adaptor.sv
// Bridges single-transfer LINE_W L2 line requests onto NBEATS-beat BEAT_W memory bursts.
// Optional stall watchdog enabled by defining L2_CACHELINE_ADAPTOR_TIMEOUT_EN.
module l2_cacheline_adaptor #(
    parameter int LINE_W         = 256,
    parameter int BEAT_W         = 64,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address_i,
    input  logic [LINE_W-1:0] line_i,
    input  logic              read_i,
    input  logic              write_i,
    output logic [LINE_W-1:0] line_o,
    output logic              resp_o,
    output logic [ADDR_W-1:0] address_o,
    output logic [BEAT_W-1:0] burst_o,
    output logic              read_o,
    output logic              write_o,
    input  logic [BEAT_W-1:0] burst_i,
    input  logic              resp_i,
    output logic              error_o
);

    localparam int NBEATS = LINE_W / BEAT_W;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int OFF_W  = $clog2(LINE_W / 8);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic [LINE_W-1:0] line_q;
    logic              last_beat;
    logic              tmo_hit;

    assign last_beat = resp_i && (cnt == CNT_W'(NBEATS - 1));

    assign read_o  = (state == READ);
    assign write_o = (state == WRITE);
    assign resp_o  = (state == DONE);

    always_comb begin
        burst_o = '0;
        if (state == WRITE)
            burst_o = line_q[BEAT_W*cnt +: BEAT_W];
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (write_i)
                    state_n = WRITE;
                else if (read_i)
                    state_n = READ;
            end
            READ, WRITE: begin
                if (last_beat || tmo_hit)
                    state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            line_q    <= '0;
            line_o    <= '0;
            address_o <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (read_i || write_i) begin
                        line_q    <= line_i;
                        // Line-align: drop the byte offset within the line.
                        address_o <= address_i & ~ADDR_W'((1 << OFF_W) - 1);
                        cnt       <= '0;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        line_o[BEAT_W*cnt +: BEAT_W] <= burst_i;
                        cnt                          <= cnt + CNT_W'(1);
                    end
                end
                WRITE: begin
                    if (resp_i)
                        cnt <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef L2_CACHELINE_ADAPTOR_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] tmo_cnt;
    logic             busy;

    assign busy    = (state == READ) || (state == WRITE);
    // Fires on the TIMEOUT_CYCLES-th consecutive stalled cycle of a burst.
    assign tmo_hit = busy && !resp_i && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            error_o <= 1'b0;
        end else begin
            if (!busy || resp_i)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (tmo_hit)
                error_o <= 1'b1;
        end
    end
`else
    localparam int tmo_unused = TIMEOUT_CYCLES;

    assign tmo_hit = 1'b0;
    assign error_o = 1'b0;
`endif

endmodule
